// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg: opcodes, FSM states and requester id shared by the ALU arbiter
package alu_share_arbiter_pkg;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;
    typedef logic req_id_t;
endpackage

// File: rtl/alu_share_arbiter_alub.sv
// alu_share_arbiter_alub: combinational ALU with zero flag; unknown opcodes yield 0
module alu_share_arbiter_alub
    import alu_share_arbiter_pkg::*;
#(
    parameter int W   = 32,
    parameter int OPW = 4
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [OPW-1:0] op,
    output logic [W-1:0]   res,
    output logic           zflag
);
    // Opcode decode; SLT is an unsigned compare
    always_comb begin
        res = op == OP_ADD ? a + b :
              op == OP_SUB ? a - b :
              op == OP_AND ? a & b :
              op == OP_OR  ? a | b :
              op == OP_NOR ? ~(a | b) :
              op == OP_SLT ? {{(W-1){1'b0}}, a < b} : '0;
    end
    assign zflag = res == '0;
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one registered ALU between two requesters
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int W   = 32,
    parameter int OPW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2*W-1:0]   req_a,
    input  logic [2*W-1:0]   req_b,
    input  logic [2*OPW-1:0] req_op,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [W-1:0]     rsp_res,
    output logic             rsp_zero,
    output logic             busy
);
    state_t         state_q, state_d;
    req_id_t        last_q, last_d, owner_q, owner_d, gnt_id;
    logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, alu_res;
    logic [OPW-1:0] op_q, op_d;
    logic           zero_q, zero_d, alu_zero, accept;
    alu_share_arbiter_alub #(.W(W), .OPW(OPW)) u_alu (
        .a    (a_q),
        .b    (b_q),
        .op   (op_q),
        .res  (alu_res),
        .zflag(alu_zero)
    );
    // Grant: contention goes to the requester that did not win last time
    always_comb begin
        gnt_id    = &req_valid ? ~last_q : req_valid[1];
        req_ready = (state_q == ST_IDLE && !rst && |req_valid) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
        accept    = |req_ready;
    end
    // Next state: latch operands on accept, capture ALU result at end of EXEC
    always_comb begin
        state_d = state_q == ST_IDLE ? (accept ? ST_EXEC : ST_IDLE) :
                  state_q == ST_EXEC ? ST_RESP :
                  (state_q == ST_RESP && !rsp_ready[owner_q]) ? ST_RESP : ST_IDLE;
        last_d  = accept ? gnt_id : last_q;
        owner_d = accept ? gnt_id : owner_q;
        a_d     = accept ? (gnt_id ? req_a[2*W-1:W] : req_a[W-1:0]) : a_q;
        b_d     = accept ? (gnt_id ? req_b[2*W-1:W] : req_b[W-1:0]) : b_q;
        op_d    = accept ? (gnt_id ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0]) : op_q;
        res_d   = state_q == ST_EXEC ? alu_res : res_q;
        zero_d  = state_q == ST_EXEC ? alu_zero : zero_q;
    end
    // State registers; reset discards any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end
    assign rsp_valid = state_q == ST_RESP ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy      = state_q != ST_IDLE;
    assign rsp_res   = res_q;
    assign rsp_zero  = zero_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed stimulus checked against a transaction-level model each cycle
module tb_alu_share_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b11;
    logic [1:0]  rsp_ready = 2'b00;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [7:0]  req_op = '0;
    logic [1:0]  req_ready, rsp_valid;
    logic [31:0] rsp_res;
    logic        rsp_zero, busy;
    int checks = 0;
    int errors = 0;

    alu_share_arbiter #(.W(32), .OPW(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_zero(rsp_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference ALU in plain arithmetic
    function automatic logic [31:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [3:0] op);
        case (op)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b1100: return ~(a | b);
            4'b0111: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Winner id: contention alternates away from the previous winner, otherwise the sole requester
    function automatic bit grant_of(logic [1:0] v, bit last);
        if (v == 2'b11) return !last;
        return v[1];
    endfunction

    // Transaction model: one pending op, one cycle of compute, then a held response
    bit          m_pending = 0;
    bit          m_computed = 0;
    bit          m_owner = 0;
    bit          m_last = 1;
    logic [31:0] m_res = '0;
    logic [31:0] m_out = '0;
    bit          m_zout = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_pending <= 0;
            m_computed <= 0;
            m_last <= 1;
            m_out <= '0;
            m_zout <= 0;
        end else if (!m_pending) begin
            if (req_valid != 2'b00) begin
                m_pending <= 1;
                m_computed <= 0;
                m_owner <= grant_of(req_valid, m_last);
                m_last <= grant_of(req_valid, m_last);
                m_res <= grant_of(req_valid, m_last)
                    ? alu_ref(req_a[63:32], req_b[63:32], req_op[7:4])
                    : alu_ref(req_a[31:0], req_b[31:0], req_op[3:0]);
            end
        end else if (!m_computed) begin
            m_computed <= 1;
            m_out <= m_res;
            m_zout <= (m_res == 32'd0);
        end else if (rsp_ready[m_owner]) begin
            m_pending <= 0;
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model on the falling edge
    task automatic neg();
        logic [1:0] exp_rdy, exp_rv;
        @(negedge clk);
        exp_rdy = (m_pending || rst || req_valid == 2'b00) ? 2'b00
                : (grant_of(req_valid, m_last) ? 2'b10 : 2'b01);
        exp_rv = (m_pending && m_computed) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        chk("model req_ready", req_ready, exp_rdy);
        chk("model rsp_valid", rsp_valid, exp_rv);
        chk("model busy", busy, m_pending);
        chk("model rsp_res", rsp_res, m_out);
        chk("model rsp_zero", rsp_zero, m_zout);
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        neg();
        pos();
    endtask

    task automatic do_op(bit id, logic [31:0] a, logic [31:0] b, logic [3:0] op,
                         logic [1:0] rr, logic [31:0] exp_res, bit exp_zero);
        req_valid = id ? 2'b10 : 2'b01;
        rsp_ready = rr;
        if (id) begin req_a[63:32] = a; req_b[63:32] = b; req_op[7:4] = op; end
        else    begin req_a[31:0] = a;  req_b[31:0] = b;  req_op[3:0] = op; end
        neg();
        chk("op ready", req_ready, id ? 2'b10 : 2'b01);
        pos();
        req_valid = 2'b00;
        neg();
        chk("op exec busy", busy, 1'b1);
        chk("op exec no rsp", rsp_valid, 2'b00);
        pos();
        neg();
        chk("op rsp_valid", rsp_valid, id ? 2'b10 : 2'b01);
        chk("op rsp_res", rsp_res, exp_res);
        chk("op rsp_zero", rsp_zero, exp_zero);
        pos();
        neg();
        chk("op back idle", busy, 1'b0);
        pos();
    endtask

    initial begin
        // reset held with both requesters valid
        for (int i = 0; i < 2; i++) begin
            neg();
            chk("reset req_ready", req_ready, 2'b00);
            chk("reset rsp_valid", rsp_valid, 2'b00);
            chk("reset rsp_res", rsp_res, 32'd0);
            chk("reset busy", busy, 1'b0);
            pos();
        end
        rst = 1'b0;
        req_valid = 2'b00;
        step();
        // single add
        do_op(0, 32'd5, 32'd7, 4'b0010, 2'b01, 32'd12, 0);
        // contention from a fresh pointer: 0,1,0,1
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_a = {32'h0000_00F0, 32'd9};
        req_b = {32'h0000_000F, 32'd9};
        req_op = {4'b0001, 4'b0110};
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            neg();
            chk("rr grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
            pos();
            step();
            neg();
            chk("rr rsp_valid", rsp_valid, (k % 2) ? 2'b10 : 2'b01);
            chk("rr rsp_res", rsp_res, (k % 2) ? 32'hFF : 32'h0);
            chk("rr rsp_zero", rsp_zero, (k % 2) ? 1'b0 : 1'b1);
            pos();
        end
        // backpressure on requester 1
        req_valid = 2'b10;
        req_a[63:32] = 32'd3;
        req_b[63:32] = 32'd4;
        req_op[7:4] = 4'b0111;
        rsp_ready = 2'b00;
        neg();
        chk("bp grant", req_ready, 2'b10);
        pos();
        neg();
        chk("bp exec ready", req_ready, 2'b00);
        pos();
        for (int i = 0; i < 5; i++) begin
            neg();
            chk("bp rsp_valid", rsp_valid, 2'b10);
            chk("bp rsp_res", rsp_res, 32'd1);
            chk("bp req_ready", req_ready, 2'b00);
            pos();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        neg();
        chk("bp wrong-owner ignored", rsp_valid, 2'b10);
        pos();
        rsp_ready = 2'b10;
        step();
        neg();
        chk("bp released", busy, 1'b0);
        pos();
        // wrap and default opcodes
        do_op(0, 32'hFFFF_FFFF, 32'd1, 4'b0010, 2'b11, 32'd0, 1);
        do_op(0, 32'd123, 32'd45, 4'b1111, 2'b11, 32'd0, 1);
        do_op(1, 32'd0, 32'd0, 4'b1100, 2'b11, 32'hFFFF_FFFF, 0);
        // reset during EXEC, after a grant to requester 0
        rsp_ready = 2'b00;
        req_a[31:0] = 32'd1;
        req_b[31:0] = 32'd1;
        req_op[3:0] = 4'b0010;
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("exec-rst no rsp", rsp_valid, 2'b00);
            pos();
        end
        req_valid = 2'b11;
        neg();
        chk("exec-rst grant0", req_ready, 2'b01);
        pos();
        req_valid = 2'b00;
        step();
        neg();
        chk("resp-rst pre", rsp_valid, 2'b01);
        rst = 1'b1;
        pos();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("resp-rst no rsp", rsp_valid, 2'b00);
            chk("resp-rst res", rsp_res, 32'd0);
            pos();
        end
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        neg();
        chk("resp-rst grant0", req_ready, 2'b01);
        pos();
        req_valid = 2'b00;
        for (int i = 0; i < 4; i++) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
